// File: rtl/vga_stream_gen.sv
// vga_stream_gen: parametrised VGA timing generator that streams pixels from an
// external frame buffer. It adds configurable sync polarity, an optional 2x
// horizontal pixel repeat and an explicit blank output. Every output is
// registered and updates only on a pixel tick.
module vga_stream_gen #(
  parameter int PIXEL_BITS       = 4,
  parameter int DIV_BITS         = 4,
  parameter int H_VISIBLE        = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_VISIBLE        = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int SYNC_ACTIVE_HIGH = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIV_BITS-1:0]   pixel_div,
  input  logic                  hscale,
  input  logic [PIXEL_BITS-1:0] frame_pixel_in,
  output logic                  h_sync_out,
  output logic                  v_sync_out,
  output logic [PIXEL_BITS-1:0] gray_out,
  output logic                  blank_out,
  output logic                  frame_next_pixel_out,
  output logic                  frame_reset_out
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  // Bounds widened to 32 bits so sync windows ending exactly at the total
  // (zero back porch) compare correctly against the narrow counters.
  localparam logic [31:0] H_VIS_L  = 32'(H_VISIBLE);
  localparam logic [31:0] V_VIS_L  = 32'(V_VISIBLE);
  localparam logic [31:0] HS_START = 32'(H_VISIBLE + H_FRONT);
  localparam logic [31:0] HS_END   = 32'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [31:0] VS_START = 32'(V_VISIBLE + V_FRONT);
  localparam logic [31:0] VS_END   = 32'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [31:0] H_LAST   = 32'(H_TOTAL - 1);
  localparam logic [31:0] V_LAST   = 32'(V_TOTAL - 1);

  localparam logic SYNC_ON = (SYNC_ACTIVE_HIGH != 0);

  // Divider and line/frame counters; divider and repeat settings are latched
  // so that mid-frame changes only land on a frame boundary.
  logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d, div_lat_q;
  logic                hs_lat_q;
  logic [HW-1:0]       h_cnt_q, h_cnt_d;
  logic [VW-1:0]       v_cnt_q, v_cnt_d;

  logic        tick, vis, h_act, v_act, line_end, frame_end, fetch;
  logic [31:0] h_ext, v_ext;

  // Decode the current counter position and compute next-state counters.
  always_comb begin
    h_ext     = 32'(h_cnt_q);
    v_ext     = 32'(v_cnt_q);
    tick      = (div_cnt_q == div_lat_q);
    vis       = (h_ext < H_VIS_L) && (v_ext < V_VIS_L);
    h_act     = (h_ext >= HS_START) && (h_ext < HS_END);
    v_act     = (v_ext >= VS_START) && (v_ext < VS_END);
    line_end  = (h_ext == H_LAST);
    frame_end = line_end && (v_ext == V_LAST);
    // With repeat enabled a pixel is consumed only on odd columns, so each
    // fetched value is shown on two consecutive ticks.
    fetch     = vis && (!hs_lat_q || h_cnt_q[0]);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_BITS'(1);
    h_cnt_d   = line_end ? '0 : h_cnt_q + HW'(1);
    v_cnt_d   = v_cnt_q;
    if (line_end) begin
      v_cnt_d = frame_end ? '0 : v_cnt_q + VW'(1);
    end
  end

  // Counters, latched settings and registered outputs; outputs change only on ticks,
  // the two buffer strobes are single-clock pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_q            <= '0;
      h_cnt_q              <= '0;
      v_cnt_q              <= '0;
      div_lat_q            <= pixel_div;
      hs_lat_q             <= hscale;
      h_sync_out           <= ~SYNC_ON;
      v_sync_out           <= ~SYNC_ON;
      gray_out             <= '0;
      blank_out            <= 1'b1;
      frame_next_pixel_out <= 1'b0;
      frame_reset_out      <= 1'b0;
    end else begin
      div_cnt_q            <= div_cnt_d;
      frame_next_pixel_out <= 1'b0;
      frame_reset_out      <= 1'b0;
      if (tick) begin
        h_cnt_q              <= h_cnt_d;
        v_cnt_q              <= v_cnt_d;
        h_sync_out           <= h_act ? SYNC_ON : ~SYNC_ON;
        v_sync_out           <= v_act ? SYNC_ON : ~SYNC_ON;
        gray_out             <= vis ? frame_pixel_in : '0;
        blank_out            <= ~vis;
        frame_next_pixel_out <= fetch;
        frame_reset_out      <= frame_end;
        if (frame_end) begin
          div_lat_q <= pixel_div;
          hs_lat_q  <= hscale;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_stream_gen.sv
// Testbench for vga_stream_gen on a small 16x8 frame. A tick-indexed reference
// model pushes expected outputs into a queue before each clock edge; a monitor
// pops and compares them on the falling edge. Scenario tasks add frame-level
// checks (pulse counts, frame length, reset behaviour).
module tb_vga_stream_gen;
  localparam int PB = 4;
  localparam int DB = 4;
  localparam int HT = 16;
  localparam int VT = 8;
  localparam int FT = HT * VT;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DB-1:0] pixel_div;
  logic          hscale;
  logic [PB-1:0] pix;

  logic          hs_lo, vs_lo, blank_lo, np_lo, fr_lo;
  logic          hs_hi, vs_hi, blank_hi, np_hi, fr_hi;
  logic [PB-1:0] gray_lo, gray_hi;

  always #5 clk = ~clk;

  vga_stream_gen #(
    .PIXEL_BITS(PB), .DIV_BITS(DB),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_div(pixel_div), .hscale(hscale),
    .frame_pixel_in(pix), .h_sync_out(hs_lo), .v_sync_out(vs_lo),
    .gray_out(gray_lo), .blank_out(blank_lo),
    .frame_next_pixel_out(np_lo), .frame_reset_out(fr_lo)
  );

  vga_stream_gen #(
    .PIXEL_BITS(PB), .DIV_BITS(DB),
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_ACTIVE_HIGH(1)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .pixel_div(pixel_div), .hscale(hscale),
    .frame_pixel_in(pix), .h_sync_out(hs_hi), .v_sync_out(vs_hi),
    .gray_out(gray_hi), .blank_out(blank_hi),
    .frame_next_pixel_out(np_hi), .frame_reset_out(fr_hi)
  );

  typedef struct {
    logic          hs_act;
    logic          vs_act;
    logic [PB-1:0] gray;
    logic          blank;
    logic          np;
    logic          fr;
  } exp_t;

  exp_t q[$];
  exp_t e;
  exp_t got;

  int checks   = 0;
  int failures = 0;

  // Reference model state: divider count, latched settings, tick index in frame.
  int m_div, m_dl, m_t;
  bit m_hs;
  // External frame-buffer model: pointer advanced by next_pixel, rewound by frame_reset.
  int ptr;
  // Per-scenario statistics.
  int ncyc, n_np, n_fr, fr_at, n_blank, n_hs, n_hs_hi, n_vs, run, max_run;

  task automatic clear_stats();
    ncyc = 0; n_np = 0; n_fr = 0; fr_at = -1; n_blank = 0;
    n_hs = 0; n_hs_hi = 0; n_vs = 0; run = 0; max_run = 0;
  endtask

  // One clock: present the buffer pixel, predict the outputs of this edge,
  // advance the clock, then update the buffer model and statistics.
  task automatic cyc();
    int  h, v;
    bit  vis;
    pix = PB'(ptr);
    if (!rst_n) begin
      m_div = 0; m_t = 0; m_dl = int'(pixel_div); m_hs = hscale;
      e.hs_act = 1'b0; e.vs_act = 1'b0; e.gray = '0; e.blank = 1'b1;
      e.np = 1'b0; e.fr = 1'b0;
    end else begin
      e.np = 1'b0;
      e.fr = 1'b0;
      if (m_div == m_dl) begin
        h = m_t % HT;
        v = m_t / HT;
        vis = (h < 8) && (v < 4);
        e.hs_act = (h >= 10) && (h <= 12);
        e.vs_act = (v >= 5) && (v <= 6);
        e.gray   = vis ? pix : '0;
        e.blank  = !vis;
        e.np     = vis && (!m_hs || (h % 2 == 1));
        if (m_t == FT - 1) begin
          e.fr = 1'b1;
          m_dl = int'(pixel_div);
          m_hs = hscale;
        end
        m_t   = (m_t + 1) % FT;
        m_div = 0;
      end else begin
        m_div++;
      end
    end
    q.push_back(e);
    @(posedge clk);
    #1;
    if (np_lo) begin
      ptr++; n_np++; run++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    if (fr_lo) begin ptr = 0; n_fr++; fr_at = ncyc; end
    if (blank_lo) n_blank++;
    if (!hs_lo) n_hs++;
    if (hs_hi) n_hs_hi++;
    if (!vs_lo) n_vs++;
    ncyc++;
  endtask

  // Scoreboard monitor: compare both instances against the predicted edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        got = q.pop_front();
        checks++;
        if (hs_lo !== ~got.hs_act || hs_hi !== got.hs_act ||
            vs_lo !== ~got.vs_act || vs_hi !== got.vs_act ||
            gray_lo !== got.gray || gray_hi !== got.gray ||
            blank_lo !== got.blank || blank_hi !== got.blank ||
            np_lo !== got.np || np_hi !== got.np ||
            fr_lo !== got.fr || fr_hi !== got.fr) begin
          failures++;
          if (failures <= 20)
            $display("FAIL scoreboard t=%0t got hs=%b/%b vs=%b/%b gray=%h/%h blank=%b/%b np=%b/%b fr=%b/%b required hs_act=%b vs_act=%b gray=%h blank=%b np=%b fr=%b",
                     $time, hs_lo, hs_hi, vs_lo, vs_hi, gray_lo, gray_hi, blank_lo, blank_hi,
                     np_lo, np_hi, fr_lo, fr_hi, got.hs_act, got.vs_act, got.gray,
                     got.blank, got.np, got.fr);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; pixel_div = '0; hscale = 1'b0; ptr = 0;
    cyc(); cyc();
    checks++;
    if ({hs_lo, vs_lo, hs_hi, vs_hi, gray_lo, blank_lo, np_lo, fr_lo} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got hs=%b vs=%b hs_hi=%b vs_hi=%b gray=%h blank=%b np=%b fr=%b required 1 1 0 0 0 1 0 0",
               hs_lo, vs_lo, hs_hi, vs_hi, gray_lo, blank_lo, np_lo, fr_lo);
    end
  endtask

  task automatic test_small_frame();
    rst_n = 1'b1;
    clear_stats();
    repeat (FT) cyc();
    checks++; if (n_np !== 32) begin failures++; $display("FAIL frame1_np got %0d required 32", n_np); end
    checks++; if (n_fr !== 1 || fr_at !== 127) begin failures++; $display("FAIL frame1_reset got count=%0d at=%0d required 1 at 127", n_fr, fr_at); end
    checks++; if (n_blank !== 96) begin failures++; $display("FAIL frame1_blank got %0d required 96", n_blank); end
    checks++; if (n_hs !== 24 || n_hs_hi !== 24) begin failures++; $display("FAIL frame1_hsync got lo=%0d hi=%0d required 24 24", n_hs, n_hs_hi); end
    checks++; if (n_vs !== 32) begin failures++; $display("FAIL frame1_vsync got %0d required 32", n_vs); end
    checks++; if (max_run !== 8) begin failures++; $display("FAIL frame1_np_run got %0d required 8", max_run); end
  endtask

  task automatic test_pixel_div();
    pixel_div = 4'd3;
    clear_stats();
    repeat (FT) cyc();
    checks++; if (n_fr !== 1 || fr_at !== 127 || n_np !== 32) begin failures++; $display("FAIL div_pending got fr=%0d at=%0d np=%0d required 1 127 32", n_fr, fr_at, n_np); end
    clear_stats();
    repeat (FT * 2) cyc();
    pixel_div = 4'd0;
    repeat (FT * 2) cyc();
    checks++; if (n_fr !== 1 || fr_at !== 511) begin failures++; $display("FAIL div3_frame got fr=%0d at=%0d required 1 at 511", n_fr, fr_at); end
    checks++; if (n_np !== 32 || max_run !== 1) begin failures++; $display("FAIL div3_np got count=%0d run=%0d required 32 1", n_np, max_run); end
    checks++; if (n_blank !== 384) begin failures++; $display("FAIL div3_blank got %0d required 384", n_blank); end
  endtask

  task automatic test_mid_change();
    clear_stats();
    repeat (40) cyc();
    pixel_div = 4'd1; hscale = 1'b1;
    repeat (FT - 40) cyc();
    checks++; if (n_fr !== 1 || fr_at !== 127 || n_np !== 32) begin failures++; $display("FAIL mid_change_current got fr=%0d at=%0d np=%0d required 1 127 32", n_fr, fr_at, n_np); end
    pixel_div = 4'd0;
    clear_stats();
    repeat (FT * 2) cyc();
    checks++; if (n_fr !== 1 || fr_at !== 255) begin failures++; $display("FAIL mid_change_next got fr=%0d at=%0d required 1 at 255", n_fr, fr_at); end
    checks++; if (n_np !== 16 || max_run !== 1) begin failures++; $display("FAIL mid_change_np got count=%0d run=%0d required 16 1", n_np, max_run); end
  endtask

  task automatic test_hscale();
    clear_stats();
    repeat (FT) cyc();
    checks++; if (n_np !== 16 || max_run !== 1) begin failures++; $display("FAIL hscale_np got count=%0d run=%0d required 16 1", n_np, max_run); end
    checks++; if (n_fr !== 1 || fr_at !== 127 || n_blank !== 96) begin failures++; $display("FAIL hscale_frame got fr=%0d at=%0d blank=%0d required 1 127 96", n_fr, fr_at, n_blank); end
  endtask

  task automatic test_reset_midline();
    repeat (20) cyc();
    rst_n = 1'b0; hscale = 1'b0; pixel_div = 4'd0; ptr = 0;
    cyc();
    checks++;
    if ({hs_lo, vs_lo, hs_hi, vs_hi, gray_lo, blank_lo, np_lo, fr_lo} !==
        {1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midline_reset got hs=%b vs=%b hs_hi=%b vs_hi=%b gray=%h blank=%b np=%b fr=%b required 1 1 0 0 0 1 0 0",
               hs_lo, vs_lo, hs_hi, vs_hi, gray_lo, blank_lo, np_lo, fr_lo);
    end
    rst_n = 1'b1;
    clear_stats();
    repeat (FT) cyc();
    checks++; if (n_fr !== 1 || fr_at !== 127 || n_np !== 32) begin failures++; $display("FAIL restart_frame got fr=%0d at=%0d np=%0d required 1 127 32", n_fr, fr_at, n_np); end
  endtask

  initial begin
    rst_n = 1'b0; pixel_div = '0; hscale = 1'b0; pix = '0; ptr = 0;
    m_div = 0; m_dl = 0; m_t = 0; m_hs = 1'b0;
    clear_stats();
    test_reset();
    test_small_frame();
    test_pixel_div();
    test_mid_change();
    test_hscale();
    test_reset_midline();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
